// File: rtl/elevator_pkg.sv
// Shared types and constants for the LOOK-scheduled elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } elevator_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Both timers share one width, wide enough for the longer of the two periods.
  function automatic int cnt_width(input int travel, input int door);
    int longest;
    longest = (travel > door) ? travel : door;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/elevator_req_tracker.sv
// Outstanding-request bitmap with set/clear ports and above/below summaries
// relative to the car position.
module elevator_req_tracker
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_set_en,
  input  logic [FLOOR_W-1:0]    i_set_floor,
  input  logic                  i_clr_en,
  input  logic [FLOOR_W-1:0]    i_clr_floor,
  input  logic [FLOOR_W-1:0]    i_curr_floor,
  input  logic [FLOOR_W-1:0]    i_query_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_any_above,
  output logic                  o_any_below,
  output logic                  o_query_hit
);

  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] w_set_vec;
  logic [NUM_FLOORS-1:0] w_clr_vec;
  logic [NUM_FLOORS-1:0] w_query_vec;
  logic [NUM_FLOORS-1:0] w_above_mask;
  logic [NUM_FLOORS-1:0] w_below_mask;

  // Index comparisons instead of shifted masks so no floor value can overflow.
  always_comb begin
    w_set_vec    = '0;
    w_clr_vec    = '0;
    w_query_vec  = '0;
    w_above_mask = '0;
    w_below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_set_vec[i]    = i_set_en && (int'(i_set_floor) == i);
      w_clr_vec[i]    = i_clr_en && (int'(i_clr_floor) == i);
      w_query_vec[i]  = (int'(i_query_floor) == i);
      w_above_mask[i] = (i > int'(i_curr_floor));
      w_below_mask[i] = (i < int'(i_curr_floor));
    end
  end

  // A clear on the same edge as a set for that floor wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending | w_set_vec) & ~w_clr_vec;
    end
  end

  assign o_pending   = r_pending;
  assign o_any_above = |(r_pending & w_above_mask);
  assign o_any_below = |(r_pending & w_below_mask);
  assign o_query_hit = |(r_pending & w_query_vec);

endmodule

// File: rtl/elevator_ctrl.sv
// LOOK-policy elevator FSM: moves floor by floor with timed travel and door
// dwell, serving requests held in the tracker bitmap.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    curr_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic                  req_err,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int CNT_W = cnt_width(TRAVEL_CYCLES, DOOR_CYCLES);
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

  elevator_state_t    r_state;
  logic [FLOOR_W-1:0] r_curr_floor;
  logic               r_dir_up;
  logic               r_moving;
  logic               r_door_open;
  logic               r_arrive;
  logic               r_req_err;
  logic [CNT_W-1:0]   r_travel_cnt;
  logic [CNT_W-1:0]   r_dwell_cnt;

  logic               w_req_ok;
  logic               w_req_at_curr;
  logic               w_set_en;
  logic               w_travel_done;
  logic [FLOOR_W-1:0] w_next_floor;
  logic               w_next_hit;
  logic               w_clr_en;
  logic               w_any_above;
  logic               w_any_below;
  logic               w_pick_up;

  assign w_req_ok      = req_valid && (int'(req_floor) < NUM_FLOORS);
  assign w_req_at_curr = w_req_ok && (req_floor == r_curr_floor);
  // A request for the floor the stationary car is at is served by the door, not stored.
  assign w_set_en      = w_req_ok && !(w_req_at_curr && (r_state == IDLE || r_state == DOOR_OPEN));
  assign w_travel_done = (r_state == MOVE_UP || r_state == MOVE_DOWN) && (r_travel_cnt == TRAVEL_LAST);
  assign w_next_floor  = (r_state == MOVE_DOWN) ? r_curr_floor - 1'b1 : r_curr_floor + 1'b1;
  assign w_clr_en      = w_travel_done && w_next_hit;
  // LOOK choice: keep the current heading while work remains on that side.
  assign w_pick_up     = r_dir_up ? w_any_above : !w_any_below;

  elevator_req_tracker #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_tracker (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_set_en      (w_set_en),
    .i_set_floor   (req_floor),
    .i_clr_en      (w_clr_en),
    .i_clr_floor   (w_next_floor),
    .i_curr_floor  (r_curr_floor),
    .i_query_floor (w_next_floor),
    .o_pending     (pending),
    .o_any_above   (w_any_above),
    .o_any_below   (w_any_below),
    .o_query_hit   (w_next_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_curr_floor <= '0;
      r_dir_up     <= DIR_UP;
      r_moving     <= 1'b0;
      r_door_open  <= 1'b0;
      r_arrive     <= 1'b0;
      r_req_err    <= 1'b0;
      r_travel_cnt <= '0;
      r_dwell_cnt  <= '0;
    end else begin
      r_arrive  <= 1'b0;
      r_req_err <= req_valid && !w_req_ok;
      case (r_state)
        IDLE: begin
          if (w_req_at_curr) begin
            r_state     <= DOOR_OPEN;
            r_door_open <= 1'b1;
            r_dwell_cnt <= '0;
          end else if (w_any_above || w_any_below) begin
            r_state      <= w_pick_up ? MOVE_UP : MOVE_DOWN;
            r_dir_up     <= w_pick_up ? DIR_UP : DIR_DOWN;
            r_moving     <= 1'b1;
            r_travel_cnt <= '0;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (w_travel_done) begin
            r_travel_cnt <= '0;
            r_curr_floor <= w_next_floor;
            if (w_next_hit) begin
              r_state     <= DOOR_OPEN;
              r_moving    <= 1'b0;
              r_door_open <= 1'b1;
              r_arrive    <= 1'b1;
              r_dwell_cnt <= '0;
            end
          end else begin
            r_travel_cnt <= r_travel_cnt + 1'b1;
          end
        end
        DOOR_OPEN: begin
          if (door_hold || w_req_at_curr) begin
            r_dwell_cnt <= '0;
          end else if (r_dwell_cnt == DOOR_LAST) begin
            r_dwell_cnt <= '0;
            r_door_open <= 1'b0;
            if (w_any_above || w_any_below) begin
              r_state      <= w_pick_up ? MOVE_UP : MOVE_DOWN;
              r_dir_up     <= w_pick_up ? DIR_UP : DIR_DOWN;
              r_moving     <= 1'b1;
              r_travel_cnt <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_dwell_cnt <= r_dwell_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign curr_floor = r_curr_floor;
  assign dir_up     = r_dir_up;
  assign moving     = r_moving;
  assign door_open  = r_door_open;
  assign arrive     = r_arrive;
  assign req_err    = r_req_err;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: a countdown-based reference model
// queues expected outputs each edge; a negedge monitor pops and compares.
module tb_elevator_ctrl;

  localparam int NF = 8;
  localparam int FW = 4;
  localparam int TC = 4;
  localparam int DC = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic          door_hold;
  logic [FW-1:0] curr_floor;
  logic          dir_up;
  logic          moving;
  logic          door_open;
  logic          arrive;
  logic          req_err;
  logic [NF-1:0] pending;

  typedef struct packed {
    logic [FW-1:0] floor;
    logic          up;
    logic          mv;
    logic          door;
    logic          arr;
    logic          err;
    logic [NF-1:0] pend;
  } exp_t;

  exp_t expQ[$];
  int   arrQ[$];
  int   checks = 0;
  int   errors = 0;

  typedef enum int {M_IDLE, M_MOVING, M_DOOR} mode_t;
  mode_t         mMode;
  int            mFloor;
  bit            mUp;
  bit [NF-1:0]   mPend;
  bit            mArr;
  bit            mErr;
  int            mTravelLeft;
  int            mDoorLeft;

  elevator_ctrl #(
    .NUM_FLOORS    (NF),
    .FLOOR_W       (FW),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_floor  (req_floor),
    .door_hold  (door_hold),
    .curr_floor (curr_floor),
    .dir_up     (dir_up),
    .moving     (moving),
    .door_open  (door_open),
    .arrive     (arrive),
    .req_err    (req_err),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  function automatic bit anyAbove(input bit [NF-1:0] p, input int f);
    for (int i = f + 1; i < NF; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit anyBelow(input bit [NF-1:0] p, input int f);
    for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  // LOOK: with work on both sides keep heading, otherwise go where the work is.
  function automatic bit chooseUp(input bit [NF-1:0] p, input int f, input bit up);
    if (anyAbove(p, f) && anyBelow(p, f)) return up;
    return anyAbove(p, f);
  endfunction

  // Reference model: evaluates each edge with remaining-time countdowns.
  always @(posedge clk) begin
    bit [NF-1:0] oldPend;
    mode_t       oldMode;
    bit          reqOk, reqHere, arrived;
    int          rf;
    exp_t        e;
    if (!rst_n) begin
      mMode = M_IDLE; mFloor = 0; mUp = 1'b1; mPend = '0;
      mArr = 1'b0; mErr = 1'b0; mTravelLeft = 0; mDoorLeft = 0;
    end else begin
      rf      = int'(req_floor);
      reqOk   = req_valid && (rf < NF);
      reqHere = reqOk && (rf == mFloor);
      oldPend = mPend;
      oldMode = mMode;
      arrived = 1'b0;
      mErr    = req_valid && !reqOk;
      mArr    = 1'b0;
      case (mMode)
        M_IDLE: begin
          if (reqHere) begin
            mMode = M_DOOR; mDoorLeft = DC;
          end else if (oldPend != '0) begin
            mUp = chooseUp(oldPend, mFloor, mUp);
            mMode = M_MOVING; mTravelLeft = TC;
          end
        end
        M_MOVING: begin
          if (mTravelLeft == 1) begin
            mFloor = mUp ? mFloor + 1 : mFloor - 1;
            mTravelLeft = TC;
            if (oldPend[mFloor]) begin
              mMode = M_DOOR; mDoorLeft = DC; mArr = 1'b1; arrived = 1'b1;
              arrQ.push_back(mFloor);
            end
          end else begin
            mTravelLeft--;
          end
        end
        M_DOOR: begin
          if (door_hold || reqHere) begin
            mDoorLeft = DC;
          end else if (mDoorLeft == 1) begin
            if (oldPend != '0) begin
              mUp = chooseUp(oldPend, mFloor, mUp);
              mMode = M_MOVING; mTravelLeft = TC;
            end else begin
              mMode = M_IDLE;
            end
          end else begin
            mDoorLeft--;
          end
        end
        default: mMode = M_IDLE;
      endcase
      if (reqOk && !(reqHere && (oldMode == M_IDLE || oldMode == M_DOOR))) mPend[rf] = 1'b1;
      if (arrived) mPend[mFloor] = 1'b0;
    end
    e.floor = FW'(mFloor);
    e.up    = mUp;
    e.mv    = (mMode == M_MOVING);
    e.door  = (mMode == M_DOOR);
    e.arr   = mArr;
    e.err   = mErr;
    e.pend  = mPend;
    expQ.push_back(e);
  end

  task automatic checkOutput(input exp_t e);
    exp_t a;
    a = '{curr_floor, dir_up, moving, door_open, arrive, req_err, pending};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL outputs @%0t: got floor=%0d up=%b mv=%b door=%b arr=%b err=%b pend=%b, want floor=%0d up=%b mv=%b door=%b arr=%b err=%b pend=%b",
               $time, a.floor, a.up, a.mv, a.door, a.arr, a.err, a.pend,
               e.floor, e.up, e.mv, e.door, e.arr, e.err, e.pend);
    end
  endtask

  // Monitor: per-cycle output check plus an arrival scoreboard keyed on arrive.
  always @(negedge clk) begin
    int f;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
    if (arrive === 1'b1) begin
      checks++;
      if (arrQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL arrival @%0t: got arrive at floor %0d, want no arrival", $time, curr_floor);
      end else begin
        f = arrQ.pop_front();
        if (int'(curr_floor) != f) begin
          errors++;
          $display("[TB] FAIL arrival_floor @%0t: got %0d, want %0d", $time, curr_floor, f);
        end
      end
    end
  end

  task automatic applyStimulus(input bit rst, input bit v, input int f, input bit h);
    @(negedge clk);
    rst_n     = !rst;
    req_valid = v;
    req_floor = FW'(f);
    door_hold = h;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic waitIdle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      if (!moving && !door_open && pending == '0) break;
    end
    checks++;
    if (k == budget) begin
      errors++;
      $display("[TB] FAIL wait_idle: got busy after %0d cycles, want idle", budget);
    end
  endtask

  task automatic waitDoor(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (door_open === 1'b1) break;
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
    end
    checks++;
    if (k == budget) begin
      errors++;
      $display("[TB] FAIL wait_door: got closed after %0d cycles, want open", budget);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_floor = '0; door_hold = 1'b0;
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);

    $display("[TB] single trip to floor 3");
    applyStimulus(1'b0, 1'b1, 3, 1'b0);
    waitIdle(200);

    $display("[TB] reversal: from 2 request 5 then 0");
    applyStimulus(1'b0, 1'b1, 2, 1'b0);
    waitIdle(200);
    applyStimulus(1'b0, 1'b1, 5, 1'b0);
    applyStimulus(1'b0, 1'b1, 0, 1'b0);
    waitIdle(400);

    $display("[TB] pick-up on the way: 1 -> 6 with 4 inserted");
    applyStimulus(1'b0, 1'b1, 1, 1'b0);
    waitIdle(200);
    applyStimulus(1'b0, 1'b1, 6, 1'b0);
    idleCycles(7);
    applyStimulus(1'b0, 1'b1, 4, 1'b0);
    waitIdle(400);

    $display("[TB] door hold and dwell reload");
    applyStimulus(1'b0, 1'b1, 4, 1'b0);
    waitDoor(200);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 0, 1'b1);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 4, 1'b0);
    waitIdle(200);

    $display("[TB] out-of-range requests");
    applyStimulus(1'b0, 1'b1, 9, 1'b0);
    applyStimulus(1'b0, 1'b1, 8, 1'b0);
    applyStimulus(1'b0, 1'b1, 15, 1'b0);
    idleCycles(3);

    $display("[TB] reset mid-travel");
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 7, 1'b0);
    applyStimulus(1'b0, 1'b1, 4, 1'b0);
    idleCycles(13);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    idleCycles(3);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      int  f;
      bit  v;
      f = (($urandom % 8) == 0) ? 8 + ($urandom % 8) : ($urandom % NF);
      v = ($urandom % 4) == 0;
      applyStimulus($urandom_range(0, 499) == 0, v, f, ($urandom % 16) == 0);
    end
    waitIdle(3000);
    idleCycles(3);

    checks++;
    if (arrQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL arrivals_left: got %0d unserved, want 0", arrQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
